// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-requester round-robin front end for one shared ALU
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   r0_valid/r0_ready, r0_a/r0_b/r0_ctrl   requester 0 handshake, operands and opcode
//   r1_valid/r1_ready, r1_a/r1_b/r1_ctrl   requester 1 handshake, operands and opcode
//   alu_a, alu_b, alu_ctrl       registered operands/opcode held on the shared ALU
//   alu_result, alu_overflow     ALU outputs, sampled on the last execute cycle
//   rsp_valid/rsp_ready          response handshake
//   rsp_id, rsp_result, rsp_overflow, rsp_err   response owner, data and flags
module alu_req_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [4:0]  r0_ctrl,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [4:0]  r1_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is loaded with EXEC_CYCLES-1 so that reaching zero marks the last execute cycle.
    localparam logic [1:0] CNT_INIT = 2'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ptr_q;          // 0: r0 wins a tie, 1: r1 wins a tie
    logic [31:0] a_q, b_q;
    logic [4:0]  ctrl_q;
    logic        id_q;
    logic [1:0]  cnt_q;
    logic [31:0] res_q;
    logic        ovf_q;
    logic        err_q;
    logic        accept;
    logic        illegal_op;
    logic        ovf_op;

    assign illegal_op = (ctrl_q > 5'b10101);
    assign ovf_op     = (ctrl_q == 5'b00011) || (ctrl_q == 5'b00100);

    always_comb begin
        state_d  = state_q;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                r0_ready = r0_valid & (~r1_valid | ~ptr_q);
                r1_ready = r1_valid & (~r0_valid |  ptr_q);
                if (r0_ready || r1_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = r0_ready | r1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
            id_q   <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            // Only one ready can be high; r1_ready alone selects the winner.
            a_q    <= r1_ready ? r1_a    : r0_a;
            b_q    <= r1_ready ? r1_b    : r0_b;
            ctrl_q <= r1_ready ? r1_ctrl : r0_ctrl;
            id_q   <= r1_ready;
            ptr_q  <= r0_ready;   // favour the other requester next time
            cnt_q  <= CNT_INIT;
        end else if (state_q == EXEC) begin
            if (cnt_q == 2'd0) begin
                res_q <= illegal_op ? 32'd0 : alu_result;
                ovf_q <= ovf_op & alu_overflow;
                err_q <= illegal_op;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_ctrl     = ctrl_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign rsp_err      = err_q;

endmodule
